btb_update_ctrl: RTL
====================

BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 SHALL have parameter BTB_SIZE, default 32, number of BTB entries (power of 2); INDEX_BITS = log2(BTB_SIZE).
REQ-002 SHALL have parameter QDEPTH, default 4, update-queue depth (power of 2, >=2).
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk (input, 1 bit) and rst (input, 1 bit).
REQ-004 upd_valid  input  1  execute stage presents a resolved branch.
REQ-005 upd_pc  input  32  PC of the resolved branch.
REQ-006 upd_target  input  32  resolved target address.
REQ-007 upd_taken  input  1  1 = install entry, 0 = invalidate entry.
REQ-008 upd_ready  output  1  queue can accept; upd_ready = queue not full.
REQ-009 flush_req  input  1  single-cycle request to invalidate the whole BTB.
REQ-010 wr_en  output  1  BTB write strobe, registered.
REQ-011 wr_idx  output  INDEX_BITS  BTB index written.
REQ-012 wr_target  output  32  target written.
REQ-013 wr_valid  output  1  valid bit written.
REQ-014 busy  output  1  state != IDLE.
REQ-015 sweep_done  output  1  one-cycle pulse on the final sweep write.

Function
REQ-016 Accept = upd_valid & upd_ready at a rising edge; push {upd_pc[INDEX_BITS+1:2], upd_target, upd_taken}.
REQ-017 FSM states: SWEEP, IDLE, DRAIN; exactly one BTB write per cycle at most.
REQ-018 IDLE: queue empty, wr_en=0; a push moves to DRAIN next cycle.
REQ-019 DRAIN: each cycle pop the head, drive wr_en=1, wr_idx, wr_target, wr_valid=taken; return to IDLE when the last entry pops and no push occurs that cycle.
REQ-020 Latency: an update accepted at edge t with the queue empty appears on wr_* after edge t+1; writes occur in acceptance order.
REQ-021 Invalidate writes (taken=0) SHALL drive wr_target=0.
REQ-022 SWEEP: sweep counter k from 0; each cycle wr_en=1, wr_idx=k, wr_valid=0, wr_target=0; sweep_done=1 with k=BTB_SIZE-1; next state DRAIN if queue non-empty, else IDLE.
REQ-023 flush_req in IDLE/DRAIN: discard all queued entries plus any same-cycle push, then enter SWEEP at k=0 on the next edge.
REQ-024 flush_req during SWEEP: discard queue and restart with k=0; no sweep_done for the aborted pass.
REQ-025 Pushes during SWEEP are accepted while not full and drained after the sweep.
REQ-026 Full queue: upd_ready=0, upd_valid ignored; a simultaneous pop and push in DRAIN is allowed when full-before-pop (upd_ready stays from registered full flag, i.e. not asserted).
REQ-027 Queue pointers wrap modulo QDEPTH; separate count of width log2(QDEPTH)+1.

Reset
REQ-028 rst asserted: state=SWEEP, k=0, queue empty, wr_en=0, wr_idx=0, wr_target=0, wr_valid=0, sweep_done=0, busy=1, upd_ready=1.
REQ-029 After reset release, the first sweep write occurs on the first edge; reset mid-operation abandons queue and sweep immediately.

Configuration
REQ-030 Macro BTB_UPD_COALESCE_EN: when defined, a push whose index equals the tail entry's index (queue non-empty, tail not being popped this cycle) overwrites the tail instead of allocating; upd_ready is unaffected.
REQ-031 Without BTB_UPD_COALESCE_EN, every accepted update allocates a new queue entry.

Structure
REQ-032 Package btb_pkg SHALL hold BTB_SIZE/QDEPTH defaults, the FSM state enum, and the queue-entry struct {idx, target, taken}.
REQ-033 Sub-module btb_upd_fifo (QDEPTH-deep, push/pop/full/empty/count) SHALL implement the queue.

Verification
REQ-034 Release reset, no updates -> 32 writes wr_idx 0..31 wr_valid=0, sweep_done at idx 31, busy=0 on the next cycle.
REQ-035 Idle, push pc=0x28 target=0x30 taken=1 -> one cycle later wr_en=1, wr_idx=10, wr_target=0x30, wr_valid=1.
REQ-036 Push 5 updates back to back during SWEEP with QDEPTH=4 -> upd_ready=0 after 4; those 4 written in order right after sweep_done.
REQ-037 Queue holds 3 entries, flush_req with simultaneous push -> no update writes; full sweep 0..31 follows.
REQ-038 flush_req at sweep k=15 -> next write idx 0, single sweep_done at end of the restarted pass.
REQ-039 With BTB_UPD_COALESCE_EN, two consecutive pushes pc=0x48 (targets 0x40, 0x44) during SWEEP -> one write idx 18 target 0x44; without it, two writes.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and defaults for the BTB update controller.
package btb_pkg;
  localparam int BTB_SIZE_DEF = 32;
  localparam int QDEPTH_DEF   = 4;
  localparam int IDX_W        = 16;
  localparam int ADDR_W       = 32;

  typedef enum logic [1:0] {SWEEP, IDLE, DRAIN} btb_state_e;

  // idx is wide enough for any supported BTB_SIZE; the top uses the low INDEX_BITS
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] target;
    logic              taken;
  } btb_upd_t;
endpackage

// File: rtl/btb_upd_fifo.sv
// Circular update queue with clear and an optional tail-overwrite port.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int QDEPTH = QDEPTH_DEF,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          ovr,
  input  logic          pop,
  input  btb_upd_t      din,
  output btb_upd_t      head,
  output btb_upd_t      tail,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  btb_upd_t        r_mem [QDEPTH];
  logic [PW-1:0]   r_wp, r_rp;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   w_tail_ptr, w_wr_ptr;

  assign w_tail_ptr = r_wp - PW'(1);
  assign w_wr_ptr   = ovr ? w_tail_ptr : r_wp;
  assign head  = r_mem[r_rp];
  assign tail  = r_mem[w_tail_ptr];
  assign count = r_cnt;
  assign full  = (r_cnt == CW'(QDEPTH));
  assign empty = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if ((push || ovr) && !clr) r_mem[w_wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) r_wp <= r_wp + PW'(1);
      if (pop)  r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/btb_update_ctrl.sv
// Serialises resolved-branch updates and whole-BTB flush sweeps onto one write port.
// Optional BTB_UPD_COALESCE_EN: a push hitting the tail entry's index overwrites it.
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int BTB_SIZE = BTB_SIZE_DEF,
  parameter int QDEPTH   = QDEPTH_DEF,
  localparam int INDEX_BITS = $clog2(BTB_SIZE),
  localparam int CW = $clog2(QDEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  upd_valid,
  input  logic [31:0]           upd_pc,
  input  logic [31:0]           upd_target,
  input  logic                  upd_taken,
  output logic                  upd_ready,
  input  logic                  flush_req,
  output logic                  wr_en,
  output logic [INDEX_BITS-1:0] wr_idx,
  output logic [31:0]           wr_target,
  output logic                  wr_valid,
  output logic                  busy,
  output logic                  sweep_done
);
  localparam logic [INDEX_BITS-1:0] K_LAST = INDEX_BITS'(BTB_SIZE - 1);

  btb_state_e            r_state, w_state_nxt;
  logic [INDEX_BITS-1:0] r_k, w_k_nxt;
  logic                  r_wr_en, r_wr_valid, r_sweep_done;
  logic [INDEX_BITS-1:0] r_wr_idx;
  logic [31:0]           r_wr_target;
  logic                  w_wr_en, w_wr_valid, w_sweep_done;
  logic [INDEX_BITS-1:0] w_wr_idx;
  logic [31:0]           w_wr_target;

  btb_upd_t              w_push_ent, w_head, w_tail;
  logic                  w_full, w_empty, w_accept, w_push, w_pop, w_ovr;
  logic [CW-1:0]         w_count, w_cnt_nxt;

  assign upd_ready  = ~w_full;
  assign w_accept   = upd_valid & upd_ready;
  assign w_push_ent = '{idx: IDX_W'(upd_pc[INDEX_BITS+1:2]), target: upd_target, taken: upd_taken};
  assign w_pop      = (r_state == DRAIN) & ~flush_req;

`ifdef BTB_UPD_COALESCE_EN
  // the tail may only be rewritten if it is not also the entry leaving this cycle
  assign w_ovr = w_accept & ~flush_req & ~w_empty & ~(w_pop & (w_count == CW'(1)))
               & (w_tail.idx == w_push_ent.idx);
`else
  assign w_ovr = 1'b0;
`endif

  assign w_push    = w_accept & ~w_ovr & ~flush_req;
  assign w_cnt_nxt = w_count + CW'(w_push) - CW'(w_pop);

  btb_upd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk(clk), .rst(rst), .clr(flush_req),
    .push(w_push), .ovr(w_ovr), .pop(w_pop), .din(w_push_ent),
    .head(w_head), .tail(w_tail), .full(w_full), .empty(w_empty), .count(w_count)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_k_nxt      = r_k;
    w_wr_en      = 1'b0;
    w_wr_idx     = r_wr_idx;
    w_wr_target  = r_wr_target;
    w_wr_valid   = r_wr_valid;
    w_sweep_done = 1'b0;
    if (flush_req) begin
      w_state_nxt = SWEEP;
      w_k_nxt     = '0;
    end else begin
      case (r_state)
        SWEEP: begin
          w_wr_en     = 1'b1;
          w_wr_idx    = r_k;
          w_wr_target = '0;
          w_wr_valid  = 1'b0;
          w_k_nxt     = r_k + 1'b1;
          if (r_k == K_LAST) begin
            w_sweep_done = 1'b1;
            w_state_nxt  = (w_cnt_nxt != '0) ? DRAIN : IDLE;
          end
        end
        IDLE: if (w_push) w_state_nxt = DRAIN;
        DRAIN: begin
          w_wr_en     = 1'b1;
          w_wr_idx    = w_head.idx[INDEX_BITS-1:0];
          w_wr_target = w_head.taken ? w_head.target : '0;
          w_wr_valid  = w_head.taken;
          if (w_cnt_nxt == '0) w_state_nxt = IDLE;
        end
        default: w_state_nxt = SWEEP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= SWEEP;
      r_k          <= '0;
      r_wr_en      <= 1'b0;
      r_wr_idx     <= '0;
      r_wr_target  <= '0;
      r_wr_valid   <= 1'b0;
      r_sweep_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_k          <= w_k_nxt;
      r_wr_en      <= w_wr_en;
      r_wr_idx     <= w_wr_idx;
      r_wr_target  <= w_wr_target;
      r_wr_valid   <= w_wr_valid;
      r_sweep_done <= w_sweep_done;
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_idx     = r_wr_idx;
  assign wr_target  = r_wr_target;
  assign wr_valid   = r_wr_valid;
  assign sweep_done = r_sweep_done;
  assign busy       = (r_state != IDLE);

  logic w_unused;
  assign w_unused = &{1'b0, upd_pc[31:INDEX_BITS+2], upd_pc[1:0],
                      w_head.idx[IDX_W-1:INDEX_BITS], w_tail, w_empty};
endmodule
